// File: rtl/chan_mux_pkg.sv
// Shared types and constants for the chan_mux registered channel multiplexer.
package chan_mux_pkg;

  typedef enum logic [1:0] {
    StIdle = 2'd0,
    StHold = 2'd1,
    StScan = 2'd2
  } state_e;

  localparam logic MODE_DIRECT = 1'b0;
  localparam logic MODE_SCAN   = 1'b1;

endpackage

// File: rtl/chan_mux_sel.sv
// Combinational N:1 W-bit selector built as log2(N) levels of 2:1 stages.
module chan_mux_sel #(
  parameter int unsigned N = 8,
  parameter int unsigned W = 1
) (
  input  logic [$clog2(N)-1:0] idx_i,
  input  logic [N*W-1:0]       d_i,
  output logic [W-1:0]         word_o
);

  localparam int unsigned SW = $clog2(N);

  logic [N*W-1:0] lvl;

  // Each level folds pairs (2j, 2j+1) into slot j, steered by one index bit, LSB first.
  always_comb begin
    lvl = d_i;
    for (int unsigned l = 0; l < SW; l++) begin
      for (int unsigned j = 0; j < (N >> (l + 1)); j++) begin
        lvl[j*W +: W] = idx_i[l] ? lvl[(2*j+1)*W +: W] : lvl[2*j*W +: W];
      end
    end
    word_o = lvl[W-1:0];
  end

endmodule

// File: rtl/chan_mux.sv
// N-channel W-bit registered multiplexer with valid/ready output handshake.
// Optional auto-scan sweep enabled by defining CHAN_MUX_SCAN_EN.
module chan_mux
  import chan_mux_pkg::*;
#(
  parameter int unsigned N = 8,
  parameter int unsigned W = 1
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  input  logic [N*W-1:0]       d_i,
  input  logic [$clog2(N)-1:0] sel_i,
  input  logic                 sel_load_i,
  input  logic                 mode_i,
  input  logic                 start_i,
  input  logic                 out_ready_i,
  output logic                 out_valid_o,
  output logic [W-1:0]         f_o,
  output logic [$clog2(N)-1:0] ch_o,
  output logic                 busy_o
);

  localparam int unsigned SW = $clog2(N);

  state_e         state_q;
  logic [SW-1:0]  cur_sel_q;
  logic [SW-1:0]  ch_q;
  logic [W-1:0]   f_q;
  logic           valid_q;

  logic [SW-1:0]  k;
  logic [SW-1:0]  mux_idx;
  logic [W-1:0]   mux_word;

  // A same-cycle sel_load takes effect for the capture it accompanies.
  assign k = sel_load_i ? sel_i : cur_sel_q;

`ifdef CHAN_MUX_SCAN_EN
  assign mux_idx = (state_q == StScan) ? ch_q + SW'(1) : k;
`else
  logic unused_mode;
  assign unused_mode = mode_i;
  assign mux_idx     = k;
`endif

  chan_mux_sel #(
    .N (N),
    .W (W)
  ) u_sel (
    .idx_i  (mux_idx),
    .d_i    (d_i),
    .word_o (mux_word)
  );

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state_q   <= StIdle;
      cur_sel_q <= '0;
      ch_q      <= '0;
      f_q       <= '0;
      valid_q   <= 1'b0;
    end else begin
      if (sel_load_i) begin
        cur_sel_q <= sel_i;
      end
      unique case (state_q)
        StIdle: begin
          if (start_i) begin
            valid_q <= 1'b1;
`ifdef CHAN_MUX_SCAN_EN
            if (mode_i == MODE_SCAN) begin
              f_q     <= d_i[W-1:0];
              ch_q    <= '0;
              state_q <= StScan;
            end else begin
              f_q     <= mux_word;
              ch_q    <= k;
              state_q <= StHold;
            end
`else
            f_q     <= mux_word;
            ch_q    <= k;
            state_q <= StHold;
`endif
          end
        end
        StHold: begin
          if (out_ready_i) begin
            valid_q <= 1'b0;
            state_q <= StIdle;
          end
        end
`ifdef CHAN_MUX_SCAN_EN
        StScan: begin
          if (out_ready_i) begin
            if (ch_q == SW'(N - 1)) begin
              valid_q <= 1'b0;
              state_q <= StIdle;
            end else begin
              f_q  <= mux_word;
              ch_q <= ch_q + SW'(1);
            end
          end
        end
`endif
        default: begin
          valid_q <= 1'b0;
          state_q <= StIdle;
        end
      endcase
    end
  end

  assign out_valid_o = valid_q;
  assign f_o         = f_q;
  assign ch_o        = ch_q;
  assign busy_o      = (state_q != StIdle);

endmodule

// File: tb/tb_chan_mux.sv
// Randomized self-checking bench for chan_mux against a transaction-level model.
module tb_chan_mux;

  localparam int unsigned N  = 8;
  localparam int unsigned W  = 4;
  localparam int unsigned SW = 3;
`ifdef CHAN_MUX_SCAN_EN
  localparam bit ScanEn = 1'b1;
`else
  localparam bit ScanEn = 1'b0;
`endif

  logic           clk = 1'b0;
  logic           rst_n;
  logic [N*W-1:0] d;
  logic [SW-1:0]  sel;
  logic           sel_load;
  logic           mode;
  logic           start;
  logic           out_ready;
  logic           out_valid;
  logic [W-1:0]   f;
  logic [SW-1:0]  ch;
  logic           busy;

  always #5 clk = ~clk;

  chan_mux #(
    .N (N),
    .W (W)
  ) dut (
    .clk_i       (clk),
    .rst_ni      (rst_n),
    .d_i         (d),
    .sel_i       (sel),
    .sel_load_i  (sel_load),
    .mode_i      (mode),
    .start_i     (start),
    .out_ready_i (out_ready),
    .out_valid_o (out_valid),
    .f_o         (f),
    .ch_o        (ch),
    .busy_o      (busy)
  );

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h", name, act, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [W-1:0] chan(input logic [N*W-1:0] dv, input int i);
    return dv[i*W +: W];
  endfunction

  // Model: one outstanding sample (direct) or a pending sweep of channels 0..N-1 (scan).
  bit            m_en = 1'b0;
  logic          m_valid, m_busy, m_scan;
  logic [SW-1:0] m_ch, m_cur;
  logic [W-1:0]  m_f;

  always @(posedge clk) begin
    int kk;
    m_en <= 1'b1;
    if (!rst_n) begin
      m_valid <= 1'b0;
      m_busy  <= 1'b0;
      m_scan  <= 1'b0;
      m_ch    <= '0;
      m_cur   <= '0;
      m_f     <= '0;
    end else begin
      kk = sel_load ? int'(sel) : int'(m_cur);
      if (sel_load) m_cur <= sel;
      if (!m_busy) begin
        if (start) begin
          m_valid <= 1'b1;
          m_busy  <= 1'b1;
          if (ScanEn && mode) begin
            m_scan <= 1'b1;
            m_ch   <= '0;
            m_f    <= chan(d, 0);
          end else begin
            m_scan <= 1'b0;
            m_ch   <= SW'(kk);
            m_f    <= chan(d, kk);
          end
        end
      end else if (out_ready) begin
        if (!m_scan || int'(m_ch) == N - 1) begin
          m_valid <= 1'b0;
          m_busy  <= 1'b0;
        end else begin
          m_ch <= m_ch + SW'(1);
          m_f  <= chan(d, int'(m_ch) + 1);
        end
      end
    end
  end

  always @(negedge clk) begin
    if (m_en) begin
      check("cycle", {23'd0, out_valid, busy, ch, f}, {23'd0, m_valid, m_busy, m_ch, m_f});
    end
  end

  initial begin
    rst_n     = 1'b0;
    start     = 1'b1;
    sel       = '0;
    sel_load  = 1'b0;
    mode      = 1'b0;
    out_ready = 1'b0;
    d         = $urandom();

    for (int i = 0; i < 2; i++) begin
      tick();
      check("rst_valid", out_valid, 1'b0);
      check("rst_f", f, 4'h0);
      check("rst_ch", ch, 3'd0);
      check("rst_busy", busy, 1'b0);
    end
    rst_n = 1'b1;
    start = 1'b0;
    tick();

    // Direct capture with same-cycle select load, then backpressure.
    d           = $urandom();
    d[5*W +: W] = 4'hA;
    sel         = 3'd5;
    sel_load    = 1'b1;
    start       = 1'b1;
    tick();
    check("dir_f", f, 4'hA);
    check("dir_ch", ch, 3'd5);
    check("dir_valid", out_valid, 1'b1);
    check("dir_busy", busy, 1'b1);
    sel_load    = 1'b0;
    d[5*W +: W] = 4'h3;
    for (int i = 0; i < 3; i++) begin
      start = (i == 1);
      sel   = (i == 1) ? 3'd2 : 3'd5;
      tick();
      check("hold_f", f, 4'hA);
      check("hold_ch", ch, 3'd5);
    end
    start     = 1'b0;
    out_ready = 1'b1;
    tick();
    check("xfer_valid", out_valid, 1'b0);
    check("xfer_busy", busy, 1'b0);
    out_ready = 1'b0;

`ifdef CHAN_MUX_SCAN_EN
    for (int i = 0; i < N; i++) d[i*W +: W] = W'(i + 1);
    mode      = 1'b1;
    start     = 1'b1;
    out_ready = 1'b1;
    tick();
    start = 1'b0;
    mode  = 1'b0;
    for (int i = 0; i < N; i++) begin
      check("scan_f", f, W'(i + 1));
      check("scan_ch", ch, SW'(i));
      tick();
    end
    check("scan_end_busy", busy, 1'b0);
    check("scan_end_valid", out_valid, 1'b0);

    mode  = 1'b1;
    start = 1'b1;
    tick();
    start = 1'b0;
    for (int i = 0; i < 3; i++) tick();
    check("bp_ch3", ch, 3'd3);
    out_ready = 1'b0;
    for (int i = 0; i < 2; i++) begin
      tick();
      check("bp_f", f, 4'h4);
      check("bp_ch", ch, 3'd3);
    end
    out_ready = 1'b1;
    tick();
    check("bp_resume_ch", ch, 3'd4);
    check("bp_resume_f", f, 4'h5);
    rst_n = 1'b0;
    tick();
    check("midrst_valid", out_valid, 1'b0);
    check("midrst_ch", ch, 3'd0);
    check("midrst_busy", busy, 1'b0);
    rst_n     = 1'b1;
    out_ready = 1'b0;
    mode      = 1'b0;
    tick();
`else
    sel      = 3'd6;
    sel_load = 1'b1;
    tick();
    sel_load = 1'b0;
    mode     = 1'b1;
    start    = 1'b1;
    tick();
    check("noscan_ch", ch, 3'd6);
    check("noscan_f", f, chan(d, 6));
    start = 1'b0;
    tick();
    check("noscan_hold_ch", ch, 3'd6);
    check("noscan_hold_busy", busy, 1'b1);
    out_ready = 1'b1;
    tick();
    check("noscan_end_valid", out_valid, 1'b0);
    check("noscan_end_busy", busy, 1'b0);
    out_ready = 1'b0;
    mode      = 1'b0;
`endif

    repeat (3000) begin
      rst_n     = ($urandom_range(0, 99) > 1);
      start     = ($urandom_range(0, 3) == 0);
      mode      = $urandom_range(0, 1) == 1;
      sel       = SW'($urandom_range(0, N - 1));
      sel_load  = ($urandom_range(0, 3) == 0);
      out_ready = ($urandom_range(0, 9) < 6);
      if ($urandom_range(0, 1) == 1) d = $urandom();
      tick();
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
